// File: rtl/mem_access_unit.sv
// mem_access_unit
// MEMORY-stage load/store engine. Accepts one load or store from the EX/MEM
// register, runs one pipelined Wishbone master cycle on the unified memory
// data port, and returns the formatted load result toward MEM/WB.
// Owns byte-lane steering, store data replication, load sign/zero extension
// and stall generation for the upstream pipeline.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses start no bus cycle; o_done and
//               o_misaligned pulse one edge after presentation.
//   undefined : offending low address bits are ignored; o_misaligned stays 0.
//
// Handshake semantics (valid/ready), in one place:
//   Upstream side : the request is "valid" when i_valid & (i_is_load |
//     i_is_store). It is consumed only in the cycle o_done=1; until then
//     o_stall=1 asks the pipeline to hold it stable. Accepted requests are
//     never relaunched because no launch happens while o_done=1.
//   Wishbone side : wb_stb is the request valid and !wb_stall its ready; a
//     request transfers on the rising edge where wb_cyc & wb_stb & !wb_stall.
//     All bus outputs are held stable while stalled. wb_ack is the response
//     valid and is only honoured in WAIT.
//
// dbg_state exposes the FSM state (0=IDLE, 1=REQ, 2=WAIT) for checkers.

module mem_access_unit #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic                  i_is_load,
    input  logic                  i_is_store,
    input  logic [2:0]            i_funct3,
    input  logic [31:0]           i_addr,
    input  logic [31:0]           i_rs2,
    output logic                  o_stall,
    output logic                  o_done,
    output logic [31:0]           o_load_data,
    output logic                  o_misaligned,
    output logic                  wb_cyc,
    output logic                  wb_stb,
    output logic                  wb_wr_en,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic [31:0]           wb_wr_data,
    output logic [3:0]            wb_sel,
    input  logic                  wb_ack,
    input  logic                  wb_stall,
    input  logic [31:0]           wb_rd_data,
    output logic [1:0]            dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]  state;
    logic        mem_op;
    logic        launch;
    logic [3:0]  req_sel;
    logic [31:0] req_wr_data;

    // Attributes of the in-flight access needed to format the load result.
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic        is_load_q;

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_fmt;

    // Address bits above the Wishbone port width do not reach memory.
    generate
        if (ADDR_WIDTH < 32) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^i_addr[31:ADDR_WIDTH];
        end
    endgenerate

    assign mem_op    = i_valid & (i_is_load | i_is_store);
    // A completed access is still presented during its o_done cycle, so
    // launching is blocked then to avoid issuing it a second time.
    assign launch    = mem_op & ~o_done;
    assign o_stall   = mem_op & ~o_done;
    assign dbg_state = state;

`ifdef MISALIGN_TRAP_EN
    logic req_misaligned;

    // Half needs addr[0]=0; word needs addr[1:0]=0; funct3 011/11x are words.
    always_comb begin
        req_misaligned = 1'b0;
        case (i_funct3[1:0])
            2'b00:   req_misaligned = 1'b0;
            2'b01:   req_misaligned = i_addr[0];
            default: req_misaligned = |i_addr[1:0];
        endcase
    end
`endif

    // Byte-lane enables and lane-replicated store data for the new request.
    always_comb begin
        req_sel     = 4'b1111;
        req_wr_data = i_rs2;
        case (i_funct3[1:0])
            2'b00: begin
                req_sel     = 4'b0001 << i_addr[1:0];
                req_wr_data = {4{i_rs2[7:0]}};
            end
            2'b01: begin
                req_sel     = 4'b0011 << {i_addr[1], 1'b0};
                req_wr_data = {2{i_rs2[15:0]}};
            end
            default: begin
                req_sel     = 4'b1111;
                req_wr_data = i_rs2;
            end
        endcase
    end

    // Right-justify the addressed byte/half of the read word and extend it.
    always_comb begin
        lane_byte = 8'h00;
        lane_half = 16'h0000;
        load_fmt  = wb_rd_data;
        case (offset_q)
            2'd0:    lane_byte = wb_rd_data[7:0];
            2'd1:    lane_byte = wb_rd_data[15:8];
            2'd2:    lane_byte = wb_rd_data[23:16];
            default: lane_byte = wb_rd_data[31:24];
        endcase
        lane_half = offset_q[1] ? wb_rd_data[31:16] : wb_rd_data[15:0];
        case (funct3_q[1:0])
            2'b00: begin
                if (funct3_q[2]) begin
                    load_fmt = {24'h000000, lane_byte};
                end else begin
                    load_fmt = {{24{lane_byte[7]}}, lane_byte};
                end
            end
            2'b01: begin
                if (funct3_q[2]) begin
                    load_fmt = {16'h0000, lane_half};
                end else begin
                    load_fmt = {{16{lane_half[15]}}, lane_half};
                end
            end
            default: load_fmt = wb_rd_data;
        endcase
    end

    // Access FSM: launch in IDLE, hold the strobe through stalls in REQ,
    // collect the ack in WAIT; also owns all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            wb_cyc       <= 1'b0;
            wb_stb       <= 1'b0;
            wb_wr_en     <= 1'b0;
            wb_addr      <= '0;
            wb_wr_data   <= 32'h0;
            wb_sel       <= 4'h0;
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
            o_load_data  <= 32'h0;
            funct3_q     <= 3'b000;
            offset_q     <= 2'b00;
            is_load_q    <= 1'b0;
        end else begin
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (launch) begin
`ifdef MISALIGN_TRAP_EN
                        if (req_misaligned) begin
                            // Trap: report completion without touching the bus.
                            o_done       <= 1'b1;
                            o_misaligned <= 1'b1;
                        end else
`endif
                        begin
                            wb_cyc     <= 1'b1;
                            wb_stb     <= 1'b1;
                            wb_wr_en   <= i_is_store;
                            wb_addr    <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
                            wb_sel     <= req_sel;
                            wb_wr_data <= req_wr_data;
                            funct3_q   <= i_funct3;
                            offset_q   <= i_addr[1:0];
                            is_load_q  <= i_is_load;
                            state      <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (!wb_stall) begin
                        wb_stb <= 1'b0;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wb_ack) begin
                        wb_cyc   <= 1'b0;
                        wb_wr_en <= 1'b0;
                        o_done   <= 1'b1;
                        if (is_load_q) begin
                            o_load_data <= load_fmt;
                        end
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    wb_cyc <= 1'b0;
                    wb_stb <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Drives loads/stores into mem_access_unit against a Wishbone slave model
// with configurable stall and ack delay. Expected bus requests and expected
// completions are queued when each access is presented and compared when
// the DUT produces them. Works with or without MISALIGN_TRAP_EN defined.

module tb_mem_access_unit;

    localparam int AW = 10;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_is_load, i_is_store;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_rs2;
    logic        o_stall, o_done, o_misaligned;
    logic [31:0] o_load_data;
    logic        wb_cyc, wb_stb, wb_wr_en;
    logic [AW-1:0] wb_addr;
    logic [31:0] wb_wr_data;
    logic [3:0]  wb_sel;
    logic        wb_ack = 1'b0;
    logic        wb_stall;
    logic [31:0] wb_rd_data = 32'h0;
    logic [1:0]  dbg_state;

    mem_access_unit #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_is_load(i_is_load), .i_is_store(i_is_store),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_rs2(i_rs2),
        .o_stall(o_stall), .o_done(o_done), .o_load_data(o_load_data),
        .o_misaligned(o_misaligned),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_wr_en(wb_wr_en),
        .wb_addr(wb_addr), .wb_wr_data(wb_wr_data), .wb_sel(wb_sel),
        .wb_ack(wb_ack), .wb_stall(wb_stall), .wb_rd_data(wb_rd_data),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- Wishbone slave model ----------------
    logic [31:0] slave_mem [256];
    int          stall_cfg = 0;
    int          ack_delay = 0;
    int          stall_seen = 0;
    bit          ack_pending = 0;
    int          ack_cnt = 0;
    logic [7:0]  slave_idx;

    assign slave_idx = wb_addr[AW-1:2];
    assign wb_stall  = wb_cyc && wb_stb && (stall_seen < stall_cfg);

    always @(posedge clk) begin
        wb_ack <= 1'b0;
        if (ack_pending) begin
            if (ack_cnt == 0) begin
                wb_ack      <= 1'b1;
                ack_pending <= 1'b0;
            end else begin
                ack_cnt <= ack_cnt - 1;
            end
        end
        if (wb_cyc && wb_stb) begin
            if (stall_seen < stall_cfg) begin
                stall_seen <= stall_seen + 1;
            end else begin
                stall_seen <= 0;
                if (wb_wr_en) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wb_sel[b]) slave_mem[slave_idx][8*b +: 8] <= wb_wr_data[8*b +: 8];
                    end
                end
                wb_rd_data <= slave_mem[slave_idx];
                if (ack_delay == 0) begin
                    wb_ack <= 1'b1;
                end else begin
                    ack_pending <= 1'b1;
                    ack_cnt     <= ack_delay - 1;
                end
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [31:0] model_mem [256];
    logic [31:0] last_load = 32'h0;
    logic [46:0] bus_q [$];   // {wr_en, addr[9:0], sel[3:0], wr_data[31:0]}
    logic [32:0] exp_q [$];   // {misaligned, load_data}
    logic [46:0] mon_bus;
    logic [32:0] mon_exp;

    function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] a);
        logic [31:0] sh;
        sh = w >> (8 * a);
        case (f3)
            3'b000: return {{24{sh[7]}}, sh[7:0]};
            3'b100: return {24'h0, sh[7:0]};
            3'b001: begin sh = w >> (16 * a[1]); return {{16{sh[15]}}, sh[15:0]}; end
            3'b101: begin sh = w >> (16 * a[1]); return {16'h0, sh[15:0]}; end
            default: return w;
        endcase
    endfunction

    always @(negedge clk) begin
        if (wb_cyc && wb_stb) begin
            if (bus_q.size() == 0) begin
                check("bus_unexpected", 1, 0);
            end else begin
                mon_bus = bus_q[0];
                check("wb_wr_en", wb_wr_en, mon_bus[46]);
                check("wb_addr", wb_addr, mon_bus[45:36]);
                check("wb_sel", wb_sel, mon_bus[35:32]);
                if (mon_bus[46]) check("wb_wr_data", wb_wr_data, mon_bus[31:0]);
                if (!wb_stall) void'(bus_q.pop_front());
            end
        end
        if (o_done) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", 1, 0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("o_misaligned", o_misaligned, mon_exp[32]);
                check("o_load_data", o_load_data, mon_exp[31:0]);
            end
        end
    end

    // ---------------- driver ----------------
    // Called just after a rising edge; returns just after a rising edge.
    task automatic do_access(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] rs2, input int stalls, input int ackd);
        int          lat;
        int          exp_lat;
        bit          mis;
        bit          trap;
        logic [31:0] w;
        logic [3:0]  sel;
        logic [31:0] wd;
        mis  = (f3[1:0] == 2'b01 && addr[0]) || (f3[1] && addr[1:0] != 2'b00);
        trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap = mis;
`endif
        case (f3[1:0])
            2'b00:   begin sel = 4'b0001 << addr[1:0]; wd = {4{rs2[7:0]}}; end
            2'b01:   begin sel = addr[1] ? 4'b1100 : 4'b0011; wd = {2{rs2[15:0]}}; end
            default: begin sel = 4'b1111; wd = rs2; end
        endcase
        if (trap) begin
            exp_lat = 1;
            exp_q.push_back({1'b1, last_load});
        end else begin
            stall_cfg = stalls;
            ack_delay = ackd;
            exp_lat   = 3 + stalls + ackd;
            bus_q.push_back({~ld, addr[AW-1:2], 2'b00, sel, wd});
            w = model_mem[addr[AW-1:2]];
            if (ld) begin
                last_load = fmt_load(w, f3, addr[1:0]);
            end else begin
                for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = wd[8*b +: 8];
                model_mem[addr[AW-1:2]] = w;
            end
            exp_q.push_back({1'b0, last_load});
        end
        i_valid = 1'b1; i_is_load = ld; i_is_store = ~ld;
        i_funct3 = f3; i_addr = addr; i_rs2 = rs2;
        #1 check("stall_on_present", o_stall, 1);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!o_done) check("stall_held", o_stall, 1);
        end while (!o_done && lat < 40);
        check("latency", lat, exp_lat);
        check("stall_done_cycle", o_stall, 0);
        @(posedge clk); #1;
        check("done_pulse", o_done, 0);
        check("no_relaunch", wb_cyc, 0);
        i_valid = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0;
    endtask

    logic [2:0] ftab [5];

    // ---------------- main sequence ----------------
    initial begin
        for (int k = 0; k < 256; k++) begin
            slave_mem[k] = 32'h0;
            model_mem[k] = 32'h0;
        end
        ftab[0] = 3'b000; ftab[1] = 3'b001; ftab[2] = 3'b010;
        ftab[3] = 3'b100; ftab[4] = 3'b101;
        rst = 1'b1; i_valid = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0;
        i_funct3 = 3'b000; i_addr = 32'h0; i_rs2 = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wb_cyc", wb_cyc, 0);
        check("rst_wb_stb", wb_stb, 0);
        check("rst_wb_wr_en", wb_wr_en, 0);
        check("rst_wb_addr", wb_addr, 0);
        check("rst_wb_sel", wb_sel, 0);
        check("rst_wb_wr_data", wb_wr_data, 0);
        check("rst_o_done", o_done, 0);
        check("rst_o_misaligned", o_misaligned, 0);
        check("rst_o_load_data", o_load_data, 0);
        check("rst_state", dbg_state, ST_IDLE);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Word store and read-back
        do_access(0, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0);
        do_access(1, 3'b010, 32'h10, 32'h0, 0, 0);
        // Byte store to top lane, signed and unsigned byte loads
        do_access(0, 3'b000, 32'h13, 32'h000000A5, 0, 0);
        do_access(1, 3'b000, 32'h13, 32'h0, 0, 0);
        do_access(1, 3'b100, 32'h13, 32'h0, 0, 0);
        // Halfword loads from both halves
        do_access(0, 3'b010, 32'h20, 32'h80017FFF, 0, 0);
        do_access(1, 3'b001, 32'h22, 32'h0, 0, 0);
        do_access(1, 3'b101, 32'h20, 32'h0, 0, 0);
        // Slave stall for two cycles, then one extra ack wait cycle
        do_access(1, 3'b010, 32'h10, 32'h0, 2, 0);
        do_access(0, 3'b001, 32'h2A, 32'h1234CAFE, 0, 1);
        do_access(1, 3'b110, 32'h28, 32'h0, 1, 1);

        // Reset while waiting for a delayed ack
        stall_cfg = 0; ack_delay = 3;
        bus_q.push_back({1'b0, 10'h010, 4'b1111, 32'h0});
        i_valid = 1'b1; i_is_load = 1'b1; i_is_store = 1'b0;
        i_funct3 = 3'b010; i_addr = 32'h10; i_rs2 = 32'h0;
        @(posedge clk); #1;
        check("req_state", dbg_state, ST_REQ);
        @(posedge clk); #1;
        check("wait_state", dbg_state, ST_WAIT);
        check("wait_cyc", wb_cyc, 1);
        check("wait_stb", wb_stb, 0);
        i_valid = 1'b0; i_is_load = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_cyc", wb_cyc, 0);
        check("midrst_stb", wb_stb, 0);
        check("midrst_state", dbg_state, ST_IDLE);
        @(negedge clk) rst = 1'b0;
        last_load = 32'h0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("late_ack_no_done", o_done, 0);
        end
        check("load_data_after_rst", o_load_data, 0);
        ack_delay = 0;
        do_access(1, 3'b010, 32'h10, 32'h0, 0, 0);

        // Misaligned word load
        do_access(1, 3'b010, 32'h21, 32'h0, 0, 0);
        // Store after a load leaves o_load_data alone
        do_access(0, 3'b000, 32'h31, 32'h00000077, 0, 0);

        // Random aligned traffic
        for (int n = 0; n < 24; n++) begin
            bit          ld;
            logic [2:0]  f3;
            logic [31:0] a;
            ld = 1'($urandom_range(0, 1));
            f3 = ld ? ftab[$urandom_range(0, 4)] : ftab[$urandom_range(0, 2)];
            a  = 32'($urandom_range(0, 15) * 4);
            if (f3[1:0] == 2'b00) a = a + 32'($urandom_range(0, 3));
            if (f3[1:0] == 2'b01) a = a + 32'($urandom_range(0, 1) * 2);
            do_access(ld, f3, a, $urandom, $urandom_range(0, 2), $urandom_range(0, 1));
        end

        repeat (3) @(posedge clk);
        #1;
        check("bus_q_drained", bus_q.size(), 0);
        check("exp_q_drained", exp_q.size(), 0);
        check("final_load_data", o_load_data, last_load);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Stage 4 (MEMORY) load/store engine: takes the load/store request from the execute/memory pipeline register, drives a pipelined Wishbone master cycle into the unified main memory data port, and returns the formatted load result. It owns byte-lane steering, store data replication, load sign/zero extension and pipeline stall generation. It sits between the EX/MEM pipeline register and the main memory data port; its output feeds the MEM/WB register.

## Interface
- ADDR_WIDTH, 10, byte-address width of the Wishbone port; must match the memory's $clog2(MEMORY_DEPTH).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  stage holds a valid instruction.
- i_is_load  in  1  instruction is LB/LH/LW/LBU/LHU.
- i_is_store  in  1  instruction is SB/SH/SW.
- i_funct3  in  3  RV32I funct3 of the access.
- i_addr  in  32  effective byte address (ALU result).
- i_rs2  in  32  store source data.
- o_stall  out  1  hold pipeline upstream of and including this stage.
- o_done  out  1  one-cycle pulse; access complete.
- o_load_data  out  32  formatted load result, valid while o_done=1 and held until the next load completes.
- o_misaligned  out  1  one-cycle pulse with o_done on a misaligned access (see Configuration).
- wb_cyc, wb_stb, wb_wr_en  out  1 each  Wishbone master controls.
- wb_addr  out  ADDR_WIDTH  word-aligned byte address; bits [1:0] always 0.
- wb_wr_data  out  32  lane-replicated store data.
- wb_sel  out  4  byte-lane enables.
- wb_ack, wb_stall  in  1 each  slave handshake.
- wb_rd_data  in  32  slave read data.

## Operation
- mem_op = i_valid & (i_is_load | i_is_store). i_is_load and i_is_store are never both 1.
- FSM states:
  - IDLE: if mem_op & !o_done, latch the request; set wb_cyc=wb_stb=1 and wb_wr_en=i_is_store, then go to REQ.
  - REQ: hold wb_stb and all bus outputs stable while wb_stall=1. When wb_stall=0, go to WAIT; wb_stb drops on that edge.
  - WAIT: wb_cyc stays 1. On wb_ack: drop wb_cyc and wb_wr_en, pulse o_done, register o_load_data for loads, return to IDLE.
- o_stall = mem_op & !o_done (combinational). No new launch is allowed in the o_done cycle, which prevents a relaunch of the instruction just completed.
- Stores, by funct3[1:0]:
  - Byte (00): wb_sel=4'b0001<<addr[1:0]; wb_wr_data={4{rs2[7:0]}}.
  - Half (01): wb_sel=4'b0011<<{addr[1],1'b0}; wb_wr_data={2{rs2[15:0]}}.
  - Otherwise: word, wb_sel=4'b1111; wb_wr_data=rs2.
- Loads: wb_sel is computed as for stores.
  - The selected byte or half is right-justified.
  - funct3[2]=0: sign-extend. funct3[2]=1: zero-extend.
  - funct3 011/11x: treated as LW.
- Stores leave o_load_data unchanged.
- wb_ack in IDLE or REQ is ignored.
- Reset (asynchronous) forces IDLE. Reset values: wb_cyc=0, wb_stb=0, wb_wr_en=0, wb_addr=0, wb_wr_data=0, wb_sel=0, o_done=0, o_misaligned=0, o_load_data=0.
- Reset mid-cycle abandons the transaction; a late ack is ignored.

## Timing
- The request is sampled at edge N (IDLE). wb_cyc and wb_stb are high from N.
- With wb_stall=0, the slave accepts at N+1; FSM goes to WAIT and stb goes low.
- The slave acks after N+1; the FSM sees it at edge N+2, and o_done and o_load_data are valid after N+2.
- Load and store latency: 3 cycles from presentation to o_done, plus k for k stall cycles and plus each extra wait cycle for ack.
- Back-to-back accesses: the next launch is at the edge after the o_done cycle, giving a minimum 4-cycle issue interval.
- All outputs except o_stall are registered.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, starts no bus cycle.
  - o_done and o_misaligned pulse at the edge after presentation.
  - o_load_data is unchanged, and no store is performed.
- MISALIGN_TRAP_EN undefined:
  - Offending low address bits are ignored (half uses addr[1] only; word ignores addr[1:0]).
  - o_misaligned is tied to 0.

## Test plan
- SW addr 0x10, rs2=0xDEADBEEF, wb_stall=0 -> wb_sel=1111, wb_addr=0x10, wb_wr_en=1, o_done 3 cycles after presentation; a following LW at 0x10 returns 0xDEADBEEF.
- SB addr 0x13, rs2=0x000000A5 -> wb_sel=1000, wb_wr_data=0xA5A5A5A5; LB at 0x13 returns 0xFFFFFFA5; LBU returns 0x000000A5.
- Memory word 0x8001_7FFF at 0x20 -> LH at 0x22 returns 0xFFFF8001; LHU at 0x20 returns 0x00007FFF; wb_sel=1100 and 0011 respectively.
- wb_stall held high 2 cycles after a request -> wb_stb, wb_addr and wb_sel stay stable for those cycles, o_done arrives at cycle 5, and o_stall stays high until the o_done cycle.
- rst pulsed while in WAIT -> wb_cyc and wb_stb drop immediately; a subsequent ack produces no o_done; the next request completes normally.
- LW at 0x21 -> MISALIGN_TRAP_EN defined: o_done and o_misaligned at cycle 1, wb_cyc never asserted. Macro undefined: access to 0x20, o_misaligned=0.
